if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: width of instr, pc and nxpc fields.
REQ-002 The block SHALL have parameter DEPTH, default 4: entry count; power of two, at least 2.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h00000013: instruction presented when the queue is empty.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port flush  input  1  discard all queued entries (branch/exception redirect).
REQ-007 The block SHALL have port in_valid  input  1  IF offers an entry.
REQ-008 The block SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-009 The block SHALL have ports instr_if, pc_if, nxpc_if  input  XLEN each  offered entry fields.
REQ-010 The block SHALL have port out_valid  output  1  head entry is valid for ID.
REQ-011 The block SHALL have port out_ready  input  1  ID consumes the head entry this cycle (deasserted while ID is stalled).
REQ-012 The block SHALL have ports instr_id, pc_id, nxpc_id  output  XLEN each  head entry fields.
REQ-013 The block SHALL have port count  output  log2(DEPTH)+1  number of stored entries.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH entries, each holding instr, pc and nxpc, with head and tail pointers that wrap modulo DEPTH.
REQ-015 A push SHALL occur when in_valid and in_ready are both high: the entry is written at tail, and tail advances at the next edge.
REQ-016 A pop SHALL occur when out_valid and out_ready are both high: head advances at the next edge.
REQ-017 in_ready SHALL equal (count < DEPTH) and not flush; a full queue does not accept a push, even when a pop happens in the same cycle.
REQ-018 out_valid SHALL equal (count > 0) and not flush, except as modified by REQ-030.
REQ-019 When out_valid is high, instr_id, pc_id and nxpc_id SHALL show the head entry, decoded combinationally from registered storage.
REQ-020 When out_valid is low, the outputs SHALL read instr_id=NOP_INSTR, pc_id=0 and nxpc_id=0.
REQ-021 count SHALL update at each edge as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 Latency SHALL be one cycle when the feature in REQ-030 is absent: an entry pushed at edge k is visible with out_valid=1 from edge k onward.
REQ-023 Flush SHALL have priority over push and pop: at the next edge count, head and tail become 0, and the same-cycle input is discarded.
REQ-024 Held data SHALL remain unchanged while out_ready=0; the head entry stays stable until it is popped.
REQ-025 Entry order SHALL be strict FIFO; entries are never reordered or duplicated.

Reset
REQ-026 When rst_n=0 at a rising edge, the block SHALL set count, head and tail to 0.
REQ-027 After reset, outputs SHALL read out_valid=0, in_ready=1, instr_id=NOP_INSTR, pc_id=0 and nxpc_id=0.
REQ-028 Reset SHALL take priority over flush, push and pop, and SHALL abort any in-flight occupancy.
REQ-029 Storage contents SHALL need no reset; they are never observable while invalid.

Configuration
REQ-030 With macro IF_ID_QUEUE_BYPASS_EN defined, the block SHALL behave as follows when count=0, in_valid=1 and flush=0: out_valid=1 and the outputs equal the inputs in the same cycle; if out_ready=1, the entry is consumed without being stored and count stays 0; if out_ready=0, the entry is stored normally.
REQ-031 Without IF_ID_QUEUE_BYPASS_EN, the block SHALL NOT have any combinational path from in_* to out_*, and REQ-022 latency SHALL apply.

Verification
REQ-032 Reset scenario: hold rst_n=0 for 2 cycles, then release -> out_valid=0, in_ready=1, instr_id=32'h00000013, count=0.
REQ-033 Fill scenario: push 4 entries with pc=0x0,0x4,0x8,0xC and out_ready=0 -> count=4 and in_ready=0; a 5th offer is not accepted; then drain with out_ready=1 -> pc_id reads 0x0,0x4,0x8,0xC, then count=0.
REQ-034 Wrap scenario: run continuous push and pop for 10 entries at count=2 -> count stays at 2, and pc_id increments by 4 each cycle across the pointer wrap.
REQ-035 Flush scenario: with count=3, assert flush together with in_valid=1 -> in_ready=0 and out_valid=0 in that cycle; next cycle count=0 and instr_id=NOP.
REQ-036 Bypass scenario with the macro defined: when empty, drive in_valid=1, instr_if=32'h00A00093 and out_ready=1 -> instr_id=32'h00A00093 in the same cycle, count stays 0. Without the macro, the same stimulus shows the value one cycle later.
REQ-037 Mid-operation reset scenario: with count=2, assert rst_n=0 together with push and pop -> next cycle count=0 and out_valid=0.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: circular FIFO between instruction fetch and decode, with flush.
// Define IF_ID_QUEUE_BYPASS_EN to forward an offered entry straight to decode when the queue is empty.
module if_id_queue #(
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 4,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [XLEN-1:0]            instr_if,
   input  logic [XLEN-1:0]            pc_if,
   input  logic [XLEN-1:0]            nxpc_if,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            instr_id,
   output logic [XLEN-1:0]            pc_id,
   output logic [XLEN-1:0]            nxpc_id,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [XLEN-1:0] instr_q [DEPTH];
   logic [XLEN-1:0] pc_q    [DEPTH];
   logic [XLEN-1:0] nxpc_q  [DEPTH];
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [AW:0]     count_q, count_d;
   logic            nonempty, wr, rd;

   assign nonempty = count_q != '0;
   assign in_ready = (count_q != FULL) && !flush;
   assign count    = count_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
   logic byp;
   assign byp       = !nonempty && in_valid && !flush;
   assign out_valid = (nonempty || byp) && !flush;
   // A bypassed entry taken by decode this cycle is never written to storage.
   assign wr        = in_valid && in_ready && !(byp && out_ready);
   assign rd        = out_valid && out_ready && !byp;
   assign instr_id  = !out_valid ? NOP_INSTR : byp ? instr_if : instr_q[head_q];
   assign pc_id     = !out_valid ? '0 : byp ? pc_if : pc_q[head_q];
   assign nxpc_id   = !out_valid ? '0 : byp ? nxpc_if : nxpc_q[head_q];
`else
   assign out_valid = nonempty && !flush;
   assign wr        = in_valid && in_ready;
   assign rd        = out_valid && out_ready;
   assign instr_id  = out_valid ? instr_q[head_q] : NOP_INSTR;
   assign pc_id     = out_valid ? pc_q[head_q] : '0;
   assign nxpc_id   = out_valid ? nxpc_q[head_q] : '0;
`endif

   always_comb begin
      head_d  = flush ? '0 : head_q + AW'(rd);
      tail_d  = flush ? '0 : tail_q + AW'(wr);
      count_d = flush ? '0 : count_q + (AW+1)'(wr) - (AW+1)'(rd);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
      if (wr) begin
         instr_q[tail_q] <= instr_if;
         pc_q[tail_q]    <= pc_if;
         nxpc_q[tail_q]  <= nxpc_if;
      end
   end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed checks of reset, fill, wrap, flush, bypass/latency and mid-operation reset.
module tb_if_id_queue;
   localparam int XLEN = 32;
   localparam int DEPTH = 4;

   logic            clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic            in_ready, out_valid;
   logic [XLEN-1:0] instr_if = '0, pc_if = '0, nxpc_if = '0;
   logic [XLEN-1:0] instr_id, pc_id, nxpc_id;
   logic [2:0]      count;
   int              checks = 0, errors = 0;

   if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(32'h00000013)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr_if(instr_if), .pc_if(pc_if), .nxpc_if(nxpc_if),
      .out_valid(out_valid), .out_ready(out_ready),
      .instr_id(instr_id), .pc_id(pc_id), .nxpc_id(nxpc_id),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] pc);
      in_valid = 1'b1;
      pc_if    = pc;
      instr_if = 32'h1000_0000 | pc;
      nxpc_if  = pc + 32'd4;
   endtask

   initial begin
      // reset held for two edges
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_instr", instr_id, 32'h00000013);
      check("rst_pc", pc_id, 0);
      check("rst_nxpc", nxpc_id, 0);
      check("rst_count", 32'(count), 0);

      // fill with decode stalled
      for (int i = 0; i < 4; i++) begin
         offer(32'(4 * i));
         #1;
         check("fill_in_ready", 32'(in_ready), 1);
         check("fill_count", 32'(count), 32'(i));
         if (i > 0) check("fill_head_stable", pc_id, 0);
         tick();
      end
      offer(32'h10);
      #1;
      check("full_count", 32'(count), 4);
      check("full_in_ready", 32'(in_ready), 0);
      check("full_out_valid", 32'(out_valid), 1);
      tick();
      check("full_reject_count", 32'(count), 4);
      // full queue refuses a push even while popping
      out_ready = 1'b1;
      #1;
      check("full_pop_in_ready", 32'(in_ready), 0);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_pc", pc_id, 32'(4 * i));
         check("drain_instr", instr_id, 32'h1000_0000 | 32'(4 * i));
         check("drain_nxpc", nxpc_id, 32'(4 * i + 4));
         tick();
      end
      check("drain_count", 32'(count), 0);
      check("drain_out_valid", 32'(out_valid), 0);

      // wrap: hold occupancy at 2 while streaming
      out_ready = 1'b0;
      offer(32'h40);
      tick();
      offer(32'h44);
      tick();
      out_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         offer(32'h48 + 32'(4 * j));
         #1;
         check("wrap_pc", pc_id, 32'h40 + 32'(4 * j));
         check("wrap_count", 32'(count), 2);
         tick();
      end
      check("wrap_end_count", 32'(count), 2);
      check("wrap_end_pc", pc_id, 32'h68);

      // flush at count 3 with a simultaneous offer
      out_ready = 1'b0;
      offer(32'h70);
      tick();
      check("pre_flush_count", 32'(count), 3);
      flush = 1'b1;
      offer(32'h74);
      #1;
      check("flush_in_ready", 32'(in_ready), 0);
      check("flush_out_valid", 32'(out_valid), 0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      check("post_flush_count", 32'(count), 0);
      check("post_flush_instr", instr_id, 32'h00000013);
      check("post_flush_out_valid", 32'(out_valid), 0);

      // bypass stimulus on an empty queue
      in_valid  = 1'b1;
      instr_if  = 32'h00A00093;
      pc_if     = 32'h80;
      nxpc_if   = 32'h84;
      out_ready = 1'b1;
      #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
      check("byp_instr", instr_id, 32'h00A00093);
      check("byp_out_valid", 32'(out_valid), 1);
      check("byp_pc", pc_id, 32'h80);
      tick();
      in_valid = 1'b0;
      #1;
      check("byp_count", 32'(count), 0);
      check("byp_after_valid", 32'(out_valid), 0);
`else
      check("lat_same_cycle_valid", 32'(out_valid), 0);
      check("lat_same_cycle_instr", instr_id, 32'h00000013);
      tick();
      in_valid = 1'b0;
      #1;
      check("lat_next_instr", instr_id, 32'h00A00093);
      check("lat_next_count", 32'(count), 1);
      tick();
      check("lat_drain_count", 32'(count), 0);
`endif

      // reset while pushing and popping at count 2
      out_ready = 1'b0;
      offer(32'h90);
      tick();
      offer(32'h94);
      tick();
      check("pre_rst_count", 32'(count), 2);
      rst_n = 1'b0;
      out_ready = 1'b1;
      offer(32'h98);
      tick();
      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      check("mid_rst_count", 32'(count), 0);
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_instr", instr_id, 32'h00000013);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
